sign_op_sequencer: RTL
======================

SIGN_OP_SEQUENCER -- requirements
Module: sign_op_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-004 SHALL have ports d0, d1, d2, d3, input, 1 bit each: one-hot operation select from the 2-to-4 decoder stage (d0 add, d1 subtract, d2 multiply, d3 divide).
REQ-005 SHALL have port a, input, 4 bits: signed two's-complement operand A.
REQ-006 SHALL have port b, input, 4 bits: signed two's-complement operand B.
REQ-007 SHALL have port result, output, 8 bits: signed result, registered.
REQ-008 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 SHALL have port err, output, 1 bit: error flag for the current result, registered.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 SHALL, in IDLE with start=1 at edge E0, capture a, b and {d3,d2,d1,d0}, enter CALC, and load step counter k: k=1 for add, sub or invalid select; k=4 for mul or div.
REQ-013 SHALL perform one step per CALC cycle, enter DONE at edge E0+k, and present final result and err there.
REQ-014 SHALL hold done=1 for exactly the DONE cycle, then return to IDLE at edge E0+k+1.
REQ-015 SHALL hold result and err stable from DONE until the next accepted start.
REQ-016 SHALL ignore start while in CALC or DONE: no re-capture and no queueing.
REQ-017 SHALL ignore operand and select changes after capture.
REQ-018 SHALL, for add, produce result = sext8(a) + sext8(b); range -16..14, no overflow possible.
REQ-019 SHALL, for sub, produce result = sext8(a) - sext8(b); range -15..15.
REQ-020 SHALL, for mul, produce the full 8-bit signed product.
REQ-021 SHALL compute mul by 4-step shift-add on operand magnitudes, negating the product when the operand signs differ; -8 x -8 = +64 (0x40).
REQ-022 SHALL, for div, produce quotient truncated toward zero in result[3:0] and remainder carrying the sign of a in result[7:4].
REQ-023 SHALL compute div by 4-step restoring division on magnitudes.
REQ-024 SHALL, for div with b=0, set err=1 and result=0x00, still taking 4 steps.
REQ-025 SHALL, for div with a=-8 and b=-1 (quotient overflow), set err=1 and result=0x00.
REQ-026 SHALL treat a captured select that is not exactly one-hot (all zero, or more than one line high) as invalid: err=1, result=0x00, k=1.
REQ-027 SHALL clear err to 0 for every valid operation without error.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, force state=IDLE, result=0x00, done=0, busy=0, err=0, and clear counter and internal operand registers.
REQ-029 SHALL abort any operation in progress on reset, with no done pulse issued for it.
REQ-030 SHALL give rst priority over start when both are 1 at the same edge; that start is not accepted.
REQ-031 SHALL accept a start on the first edge after rst deasserts.

Verification
REQ-032 SHALL cover add/sub: a=0111, b=0011, d0 -> result=0x0A, err=0, done at E0+1; a=1000, b=0111, d1 -> result=0xF1.
REQ-033 SHALL cover mul: a=1101, b=0110, d2 -> result=0xEE at E0+4; a=1000, b=1000 -> 0x40; busy=1 for cycles E0..E0+4.
REQ-034 SHALL cover div: a=1001, b=0010, d3 -> result=0xFD (q=-3, r=-1); a=0101, b=0000 -> err=1, result=0x00; a=1000, b=1111 -> err=1.
REQ-035 SHALL cover invalid select: d0..d3=0000, then 0101 -> err=1, result=0x00, done at E0+1.
REQ-036 SHALL cover handshake: start held high continuously -> operations accepted only from IDLE; a second start during CALC is not captured.
REQ-037 SHALL cover reset: rst=1 at E0+2 of a mul -> no done pulse, all outputs 0 next cycle; rst and start together -> start not accepted.

Source files
------------

// File: rtl/sign_op_sequencer.sv
// Sequenced signed 4-bit ALU: add/sub in one step, multiply and divide in
// four shift-add / restoring steps on operand magnitudes.
module sign_op_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       d0,
   input  logic       d1,
   input  logic       d2,
   input  logic       d3,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] result,
   output logic       done,
   output logic       busy,
   output logic       err
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   localparam logic [3:0] SEL_ADD = 4'b0001;
   localparam logic [3:0] SEL_SUB = 4'b0010;
   localparam logic [3:0] SEL_MUL = 4'b0100;
   localparam logic [3:0] SEL_DIV = 4'b1000;

   state_t     state;
   logic [2:0] cnt;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic [3:0] sel;
   logic [7:0] acc;
   logic [7:0] mcand;
   logic [3:0] mplier;
   logic [4:0] rem;
   logic [3:0] quo;

   logic [3:0] sel_in;
   logic [7:0] acc_next;
   logic [4:0] rem_shift;
   logic [4:0] rem_next;
   logic [3:0] quo_next;
   logic [3:0] divisor;
   logic [3:0] q_signed;
   logic [3:0] r_signed;
   logic [7:0] add_res;
   logic [7:0] sub_res;
   logic [7:0] mul_res;
   logic [7:0] div_res;
   logic       div_err;

   function automatic logic [3:0] mag4(input logic [3:0] v);
      return v[3] ? (4'd0 - v) : v;
   endfunction

   function automatic logic [7:0] sext8(input logic [3:0] v);
      return {{4{v[3]}}, v};
   endfunction

   // Next-step values for the iterative datapaths and final result formatting
   always_comb begin
      sel_in    = {d3, d2, d1, d0};
      divisor   = mag4(op_b);
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end else begin
         acc_next = acc;
      end
      rem_shift = {rem[3:0], quo[3]};
      if (rem_shift >= {1'b0, divisor}) begin
         rem_next = rem_shift - {1'b0, divisor};
         quo_next = {quo[2:0], 1'b1};
      end else begin
         rem_next = rem_shift;
         quo_next = {quo[2:0], 1'b0};
      end
      add_res  = sext8(op_a) + sext8(op_b);
      sub_res  = sext8(op_a) - sext8(op_b);
      mul_res  = (op_a[3] ^ op_b[3]) ? (8'd0 - acc_next) : acc_next;
      q_signed = (op_a[3] ^ op_b[3]) ? (4'd0 - quo_next) : quo_next;
      r_signed = op_a[3] ? (4'd0 - rem_next[3:0]) : rem_next[3:0];
      // -8 / -1 would need a +8 quotient, which does not fit in 4 bits
      div_err  = (op_b == 4'd0) || ((op_a == 4'b1000) && (op_b == 4'b1111));
      div_res  = div_err ? 8'h00 : {r_signed, q_signed};
   end

   // Control FSM, step counter, iterative datapath registers and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 3'd0;
         op_a   <= 4'd0;
         op_b   <= 4'd0;
         sel    <= 4'd0;
         acc    <= 8'd0;
         mcand  <= 8'd0;
         mplier <= 4'd0;
         rem    <= 5'd0;
         quo    <= 4'd0;
         result <= 8'h00;
         done   <= 1'b0;
         busy   <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_a   <= a;
                  op_b   <= b;
                  sel    <= sel_in;
                  acc    <= 8'd0;
                  mcand  <= {4'd0, mag4(a)};
                  mplier <= mag4(b);
                  rem    <= 5'd0;
                  quo    <= mag4(a);
                  cnt    <= ((sel_in == SEL_MUL) || (sel_in == SEL_DIV)) ? 3'd4 : 3'd1;
                  state  <= CALC;
                  busy   <= 1'b1;
               end else begin
                  state  <= IDLE;
                  busy   <= 1'b0;
               end
            end
            CALC: begin
               acc    <= acc_next;
               mcand  <= {mcand[6:0], 1'b0};
               mplier <= {1'b0, mplier[3:1]};
               rem    <= rem_next;
               quo    <= quo_next;
               if (cnt == 3'd1) begin
                  cnt   <= 3'd0;
                  state <= DONE;
                  done  <= 1'b1;
                  case (sel)
                     SEL_ADD: begin result <= add_res; err <= 1'b0;    end
                     SEL_SUB: begin result <= sub_res; err <= 1'b0;    end
                     SEL_MUL: begin result <= mul_res; err <= 1'b0;    end
                     SEL_DIV: begin result <= div_res; err <= div_err; end
                     default: begin result <= 8'h00;   err <= 1'b1;    end
                  endcase
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
